drum_iteration_scheduler: RTL and testbench
===========================================

Name: drum_iteration_scheduler

Overview:
- Sequences one drum-simulation time step across an array of NUM_COLS node-column engines: column re-init, then per audio sample a broadcast iteration start and a wait for all columns to finish.
- Captures the centre-node amplitude after each step and hands it to the audio path over a valid/ready handshake.
- Reports per-step cycle count, worst case, sample overruns and watchdog timeouts to the HPS-facing CSR block.

Parameters:
- NUM_COLS, 32, number of column engines scheduled
- RESET_CYCLES, 4, cycles col_reset is held during re-init
- TIMEOUT, 16'd4000, max cycles from iteration_enable to all-done before watchdog trip
- GUARD_CYCLES, 2, cycles after iteration_enable during which col_done is ignored

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- start  in  1  level; 1 = run, 0 = return to IDLE after current step
- reinit  in  1  one-cycle pulse; re-initialise all columns (new init/rho config)
- col_done  in  NUM_COLS  per-column "in ITERATION_DONE" flag
- center_node_in  in  18  signed 1.17 centre amplitude from the centre column
- sample_tick  in  1  one-cycle pulse at audio sample rate (48 kHz)
- audio_ready  in  1  audio FIFO can accept
- col_reset  out  1  reset broadcast to all columns
- iteration_enable  out  1  one-cycle start-step broadcast
- audio_data  out  18  signed captured centre amplitude
- audio_valid  out  1  audio_data valid
- step_cycles  out  16  cycles taken by last completed step
- max_step_cycles  out  16  worst step since reset/reinit
- overrun_count  out  16  saturating count of sample_ticks missed
- timeout_err  out  1  sticky watchdog flag

Behaviour:
- Reset values: col_reset=1, iteration_enable=0, audio_valid=0, audio_data=0, step_cycles=0, max_step_cycles=0, overrun_count=0, timeout_err=0; state=IDLE.
- States: IDLE, COL_RST, WAIT_INIT, WAIT_TICK, ISSUE, GUARD, RUN, EMIT.
- IDLE: col_reset=1; start=1 -> COL_RST.
- COL_RST: col_reset=1 for exactly RESET_CYCLES cycles, then WAIT_INIT with col_reset=0.
- WAIT_INIT: wait until &col_done, then WAIT_TICK. The columns' load phase ends in ITERATION_DONE, so done asserts after init.
- WAIT_TICK: on sample_tick -> ISSUE. If start=0 -> IDLE.
- ISSUE: iteration_enable=1 for this single cycle; cycle counter cleared to 1 -> GUARD.
- GUARD: ignore col_done for GUARD_CYCLES cycles, since columns leave ITERATION_DONE one cycle after the enable. Then -> RUN.
- RUN: cycle counter increments each cycle.
  - On &col_done: latch step_cycles=counter; max_step_cycles=max(old, counter); audio_data=center_node_in; -> EMIT.
  - If counter reaches TIMEOUT: set timeout_err, -> COL_RST (full re-init). No audio sample is produced.
- EMIT: audio_valid=1 until audio_ready seen high on a clock edge. Transfer on valid&ready; audio_valid drops the next cycle. Then -> WAIT_TICK.
  - audio_data must stay stable while valid and not ready.
- Overrun: a sample_tick in ISSUE/GUARD/RUN/EMIT increments overrun_count, saturating at 16'hFFFF. The tick is not queued; the next step waits for the next tick.
- reinit pulse in any state except IDLE: abort the current step, drop audio_valid without transfer, -> COL_RST. Also clears max_step_cycles and overrun_count. timeout_err is cleared only by reset or reinit.
- reinit and sample_tick in the same cycle: reinit wins; the tick is not counted.
- start deasserted mid-step: the step completes through EMIT, then -> IDLE.
- reset mid-operation: immediate return to reset values; columns held in reset via col_reset=1.
- All counters are unsigned 16-bit; step_cycles saturates at 16'hFFFF (unreachable when TIMEOUT < 65535).

Decomposition:
- Shared package drum_pkg: state enum, NODE_W=18, CNT_W=16, fixed-point format note (1.17).
- One natural sub-module: step_timer, which holds the cycle counter, max tracker and timeout compare, with clear/enable/latch inputs.
- The FSM, overrun counter and audio handshake stay in the top.

Test Plan:
- Reset then start=1 (all col_done=1 after 10 cycles) -> col_reset high for 4 cycles after IDLE exit; no iteration_enable before the first sample_tick.
- sample_tick; col_done drops at ISSUE+1 and all rise 50 cycles after the enable, center_node_in=18'h01234 -> iteration_enable exactly 1 cycle wide; step_cycles=50; audio_data=18'h01234 with audio_valid=1.
- audio_ready held 0 for 5 cycles then 1 -> audio_valid high 6 cycles, data stable, single transfer, back to WAIT_TICK.
- Second sample_tick while in RUN -> overrun_count=1; no extra iteration_enable. After 65536 such ticks -> holds 16'hFFFF.
- One column never asserts done -> timeout_err=1 after TIMEOUT=4000 cycles; col_reset re-asserted for 4 cycles; no audio_valid.
- reinit during EMIT with audio_ready=0 -> audio_valid=0 next cycle; max_step_cycles=0 and overrun_count=0; COL_RST entered.

Source files
------------

// File: rtl/drum_pkg.sv
// Shared types and widths for the drum iteration scheduler.
// Centre-node amplitudes are signed 1.17 fixed point: 1 sign/integer bit, 17 fraction bits.
package drum_pkg;

  localparam int NODE_W = 18;
  localparam int CNT_W  = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COL_RST,
    S_WAIT_INIT,
    S_WAIT_TICK,
    S_ISSUE,
    S_GUARD,
    S_RUN,
    S_EMIT
  } state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/drum_iteration_scheduler_if.sv
// Column-array broadcast/done bus plus the audio valid/ready stream.
// master = scheduler side, slave = column array / audio FIFO side.
interface drum_iteration_scheduler_if
  import drum_pkg::*;
#(
  parameter int NUM_COLS = 32
) ();

  logic                     col_reset;
  logic                     iteration_enable;
  logic [NUM_COLS-1:0]      col_done;
  logic signed [NODE_W-1:0] center_node_in;
  logic signed [NODE_W-1:0] audio_data;
  logic                     audio_valid;
  logic                     audio_ready;

  modport master (
    output col_reset,
    output iteration_enable,
    input  col_done,
    input  center_node_in,
    output audio_data,
    output audio_valid,
    input  audio_ready
  );

  modport slave (
    input  col_reset,
    input  iteration_enable,
    output col_done,
    output center_node_in,
    input  audio_data,
    input  audio_valid,
    output audio_ready
  );

endinterface

// File: rtl/drum_iteration_scheduler_step_timer.sv
// Per-step cycle counter with last/worst-case capture and watchdog compare.
// The counter restarts at 1 on the enable cycle so a finished step reports
// the distance from iteration_enable to the cycle all columns were done.
module drum_iteration_scheduler_step_timer
  import drum_pkg::*;
#(
  parameter logic [CNT_W-1:0] TIMEOUT = 16'd4000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic             latch,
  input  logic             clear_max,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] step_cycles,
  output logic [CNT_W-1:0] max_step_cycles,
  output logic             timeout_hit
);

  // Running step counter, saturating so it never wraps past the watchdog.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= CNT_W'(1);
    end else if (enable) begin
      count <= sat_inc(count);
    end
  end

  // Capture the finished step and track the worst case since reset/reinit.
  always_ff @(posedge clk) begin
    if (reset) begin
      step_cycles     <= '0;
      max_step_cycles <= '0;
    end else begin
      if (latch) begin
        step_cycles <= count;
      end
      if (clear_max) begin
        max_step_cycles <= '0;
      end else if (latch && (count > max_step_cycles)) begin
        max_step_cycles <= count;
      end
    end
  end

  assign timeout_hit = (count >= TIMEOUT);

endmodule

// File: rtl/drum_iteration_scheduler.sv
// Sequences one drum time step per audio sample across the column array:
// re-init, broadcast enable, wait for all columns, hand the centre amplitude
// to the audio path, and keep step timing / overrun / watchdog status.
module drum_iteration_scheduler
  import drum_pkg::*;
#(
  parameter int               NUM_COLS     = 32,
  parameter int               RESET_CYCLES = 4,
  parameter logic [CNT_W-1:0] TIMEOUT      = 16'd4000,
  parameter int               GUARD_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             reinit,
  input  logic             sample_tick,
  drum_iteration_scheduler_if.master bus,
  output logic [CNT_W-1:0] step_cycles,
  output logic [CNT_W-1:0] max_step_cycles,
  output logic [CNT_W-1:0] overrun_count,
  output logic             timeout_err
);

  localparam int RC_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(RESET_CYCLES - 1);

  state_t                   state;
  state_t                   state_nxt;
  logic [RC_W-1:0]          rst_cnt;
  logic [NUM_COLS-1:0]      done_vec;
  logic                     all_done;
  logic                     abort;
  logic                     in_step;
  logic                     step_done;
  logic                     step_timeout;
  logic                     guard_over;
  logic [CNT_W-1:0]         cnt;
  logic                     timeout_hit;
  logic                     col_reset;
  logic                     iteration_enable;
  logic                     audio_valid;
  logic signed [NODE_W-1:0] audio_data;

  assign done_vec = bus.col_done;
  assign all_done = &done_vec;

  // reinit is ignored while idle; everywhere else it aborts the step.
  assign abort      = reinit && (state != S_IDLE);
  assign in_step    = (state == S_ISSUE) || (state == S_GUARD) ||
                      (state == S_RUN)   || (state == S_EMIT);
  assign step_done  = (state == S_RUN) && all_done && !abort;
  // Done on the same cycle as the watchdog limit still counts as a finished step.
  assign step_timeout = (state == S_RUN) && !all_done && timeout_hit && !abort;
  // The timer counts from 1 at the enable, so it doubles as the guard counter.
  assign guard_over = (cnt >= CNT_W'(GUARD_CYCLES));

  drum_iteration_scheduler_step_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_step_timer (
    .clk             (clk),
    .reset           (reset),
    .clear           (state == S_ISSUE),
    .enable          ((state == S_GUARD) || (state == S_RUN)),
    .latch           (step_done),
    .clear_max       (abort),
    .count           (cnt),
    .step_cycles     (step_cycles),
    .max_step_cycles (max_step_cycles),
    .timeout_hit     (timeout_hit)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and Moore outputs; reinit overrides every transition.
  always_comb begin
    state_nxt        = state;
    col_reset        = 1'b0;
    iteration_enable = 1'b0;
    audio_valid      = 1'b0;
    case (state)
      S_IDLE: begin
        col_reset = 1'b1;
        if (start) state_nxt = S_COL_RST;
      end
      S_COL_RST: begin
        col_reset = 1'b1;
        if (rst_cnt == RC_LAST) state_nxt = S_WAIT_INIT;
      end
      S_WAIT_INIT: begin
        if (all_done) state_nxt = S_WAIT_TICK;
      end
      S_WAIT_TICK: begin
        if (!start)           state_nxt = S_IDLE;
        else if (sample_tick) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        iteration_enable = 1'b1;
        state_nxt        = S_GUARD;
      end
      S_GUARD: begin
        if (guard_over) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (all_done)         state_nxt = S_EMIT;
        else if (timeout_hit) state_nxt = S_COL_RST;
      end
      S_EMIT: begin
        audio_valid = 1'b1;
        if (bus.audio_ready) state_nxt = start ? S_WAIT_TICK : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (abort) state_nxt = S_COL_RST;
  end

  // Column reset hold counter; restarts on every entry to COL_RST, including reinit within it.
  always_ff @(posedge clk) begin
    if (reset || (state != S_COL_RST) || abort) begin
      rst_cnt <= '0;
    end else if (rst_cnt != RC_LAST) begin
      rst_cnt <= rst_cnt + RC_W'(1);
    end
  end

  // Missed sample ticks while a step is in flight; reinit clears and wins over a same-cycle tick.
  always_ff @(posedge clk) begin
    if (reset || abort) begin
      overrun_count <= '0;
    end else if (sample_tick && in_step) begin
      overrun_count <= sat_inc(overrun_count);
    end
  end

  // Sticky watchdog flag, cleared only by reset or reinit.
  always_ff @(posedge clk) begin
    if (reset || abort) begin
      timeout_err <= 1'b0;
    end else if (step_timeout) begin
      timeout_err <= 1'b1;
    end
  end

  // Centre amplitude capture; only written in RUN so it holds through EMIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      audio_data <= '0;
    end else if (step_done) begin
      audio_data <= bus.center_node_in;
    end
  end

  assign bus.col_reset        = col_reset;
  assign bus.iteration_enable = iteration_enable;
  assign bus.audio_valid      = audio_valid;
  assign bus.audio_data       = audio_data;

endmodule

// File: tb/tb_drum_iteration_scheduler.sv
// Directed bench for drum_iteration_scheduler with hand-computed expectations.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_drum_iteration_scheduler;

  localparam int NUM_COLS = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        reinit;
  logic        sample_tick;
  logic [15:0] step_cycles;
  logic [15:0] max_step_cycles;
  logic [15:0] overrun_count;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;
  int en_cnt = 0;
  int vld_cnt = 0;
  int xfer_cnt = 0;

  drum_iteration_scheduler_if #(.NUM_COLS(NUM_COLS)) bus ();

  drum_iteration_scheduler #(
    .NUM_COLS     (NUM_COLS),
    .RESET_CYCLES (4),
    .TIMEOUT      (16'd4000),
    .GUARD_CYCLES (2)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .reinit          (reinit),
    .sample_tick     (sample_tick),
    .bus             (bus),
    .step_cycles     (step_cycles),
    .max_step_cycles (max_step_cycles),
    .overrun_count   (overrun_count),
    .timeout_err     (timeout_err)
  );

  always #5 clk = ~clk;

  // Edge-accurate event counters: enables issued, valid cycles, transfers.
  always @(posedge clk) begin
    if (bus.iteration_enable) en_cnt <= en_cnt + 1;
    if (bus.audio_valid) vld_cnt <= vld_cnt + 1;
    if (bus.audio_valid && bus.audio_ready) xfer_cnt <= xfer_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_tick();
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
  endtask

  // Count consecutive col_reset-high samples, the current one included.
  task automatic count_col_reset(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (!bus.col_reset) break;
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int n;
    int e0;
    int x0;
    int v0;
    int vcnt;
    int bad;
    int d;

    reset = 1'b1; start = 1'b0; reinit = 1'b0; sample_tick = 1'b0;
    bus.col_done = '0; bus.center_node_in = '0; bus.audio_ready = 1'b0;
    cyc(3);

    check("rst_col_reset", bus.col_reset, 1);
    check("rst_iter_en", bus.iteration_enable, 0);
    check("rst_audio_valid", bus.audio_valid, 0);
    check("rst_audio_data", {14'd0, bus.audio_data}, 0);
    check("rst_step_cycles", step_cycles, 0);
    check("rst_max_step", max_step_cycles, 0);
    check("rst_overrun", overrun_count, 0);
    check("rst_timeout_err", timeout_err, 0);

    // Start: COL_RST for 4 cycles, then wait for columns to finish loading.
    reset = 1'b0;
    start = 1'b1;
    @(negedge clk);
    count_col_reset(n);
    check("start_col_reset_cycles", n, 4);
    cyc(6);
    bus.col_done = '1;
    cyc(10);
    check("no_enable_before_tick", en_cnt, 0);
    check("col_reset_low_wait_tick", bus.col_reset, 0);

    // Step 1: done 50 cycles after the enable, slow audio sink.
    e0 = en_cnt;
    bus.center_node_in = 18'h01234;
    pulse_tick();
    check("s1_enable", bus.iteration_enable, 1);
    bus.col_done = '0;
    cyc(50);
    bus.col_done = '1;
    @(negedge clk);
    check("s1_enable_width", en_cnt - e0, 1);
    check("s1_audio_valid", bus.audio_valid, 1);
    check("s1_audio_data", {14'd0, bus.audio_data}, 32'h01234);
    check("s1_step_cycles", step_cycles, 50);
    check("s1_max_step", max_step_cycles, 50);
    bus.center_node_in = 18'h2AAAA;
    x0 = xfer_cnt;
    vcnt = 0;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      if (!bus.audio_valid) break;
      vcnt++;
      if (bus.audio_data !== 18'h01234) bad++;
      bus.audio_ready = (vcnt >= 6);
      @(negedge clk);
    end
    bus.audio_ready = 1'b0;
    check("s1_valid_cycles", vcnt, 6);
    check("s1_transfers", xfer_cnt - x0, 1);
    check("s1_data_stable", bad, 0);

    // Step 2: extra tick during RUN counts as an overrun, no second enable.
    e0 = en_cnt;
    pulse_tick();
    check("s2_enable", bus.iteration_enable, 1);
    bus.col_done = '0;
    cyc(10);
    sample_tick = 1'b1;
    cyc(1);
    sample_tick = 1'b0;
    cyc(19);
    bus.col_done = '1;
    @(negedge clk);
    check("s2_overrun", overrun_count, 1);
    check("s2_step_cycles", step_cycles, 30);
    check("s2_max_step", max_step_cycles, 50);
    check("s2_enable_count", en_cnt - e0, 1);
    check("s2_audio_valid", bus.audio_valid, 1);
    bus.audio_ready = 1'b1;
    @(negedge clk);
    bus.audio_ready = 1'b0;
    check("s2_valid_drop", bus.audio_valid, 0);

    // Step 3: stall in EMIT and flood ticks until the overrun count saturates.
    bus.center_node_in = 18'h3FFF0;
    pulse_tick();
    check("s3_enable", bus.iteration_enable, 1);
    bus.col_done = '0;
    cyc(20);
    bus.col_done = '1;
    @(negedge clk);
    check("s3_step_cycles", step_cycles, 20);
    sample_tick = 1'b1;
    cyc(65536);
    sample_tick = 1'b0;
    check("s3_overrun_sat", overrun_count, 32'hFFFF);
    check("s3_valid_held", bus.audio_valid, 1);
    check("s3_data_neg", {14'd0, bus.audio_data}, 32'h3FFF0);
    check("s3_max_step", max_step_cycles, 50);

    // reinit while EMIT waits on a not-ready sink.
    x0 = xfer_cnt;
    reinit = 1'b1;
    @(negedge clk);
    reinit = 1'b0;
    check("ri_valid_drop", bus.audio_valid, 0);
    check("ri_max_clear", max_step_cycles, 0);
    check("ri_overrun_clear", overrun_count, 0);
    check("ri_no_transfer", xfer_cnt - x0, 0);
    count_col_reset(n);
    check("ri_col_reset_cycles", n, 4);
    check("ri_step_kept", step_cycles, 20);

    // Watchdog: column 5 never finishes.
    cyc(2);
    v0 = vld_cnt;
    pulse_tick();
    check("wd_enable", bus.iteration_enable, 1);
    bus.col_done = ~(32'd1 << 5);
    d = 0;
    for (int i = 0; i < 4100; i++) begin
      @(negedge clk);
      d++;
      if (bus.col_reset) break;
    end
    check("wd_latency", d, 4001);
    check("wd_timeout_err", timeout_err, 1);
    check("wd_no_audio", vld_cnt - v0, 0);
    count_col_reset(n);
    check("wd_col_reset_cycles", n, 4);
    cyc(5);
    check("wd_err_sticky", timeout_err, 1);
    check("wd_step_kept", step_cycles, 20);
    reinit = 1'b1;
    @(negedge clk);
    reinit = 1'b0;
    check("wd_err_cleared", timeout_err, 0);

    // start=0 in WAIT_TICK returns to IDLE and ignores ticks.
    bus.col_done = '1;
    cyc(8);
    start = 1'b0;
    cyc(2);
    check("idle_col_reset", bus.col_reset, 1);
    e0 = en_cnt;
    pulse_tick();
    cyc(3);
    check("idle_no_enable", en_cnt - e0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
